axonerve_kvs_rtl_example_axi_read_master: RTL and testbench

//  AXI4 read master for the KVS RTL kernel. Takes a (base address, byte count) job from kernel

---
 rtl/axonerve_kvs_rtl_example_axi_read_master.sv | 177 +++++++++++++++++
 tb/tb_axonerve_kvs_rtl_example_axi_read_master.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axonerve_kvs_rtl_example_axi_read_master.sv
// AXI4 read master for the KVS RTL kernel: splits a (base, byte count) job into INCR bursts,
// caps outstanding ARs and forwards R beats unbuffered as an AXI4-Stream.
module axonerve_kvs_rtl_example_axi_read_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
    parameter int unsigned C_BURST_LEN        = 64,
    parameter int unsigned C_MAX_OUTSTANDING  = 16
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic                          ctrl_start,
    output logic                          ctrl_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                          m_axi_rlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast
);

    localparam int unsigned AW          = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned XW1         = C_XFER_SIZE_WIDTH + 1;
    localparam int unsigned BPB         = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned LOG_BPB     = $clog2(BPB);
    localparam int unsigned LOG_BURST   = $clog2(C_BURST_LEN);
    localparam int unsigned BURST_BYTES = C_BURST_LEN * BPB;
    localparam int unsigned OW          = $clog2(C_MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_t;

    state_t           state_q;
    logic             done_q;
    logic             arvalid_q;
    logic [AW-1:0]    araddr_q;
    logic [7:0]       arlen_q;
    logic [7:0]       last_arlen_q;
    logic [XW1-1:0]   bursts_left_q;
    logic [XW1-1:0]   total_beats_q;
    logic [XW1-1:0]   beats_rcvd_q;
    logic [OW-1:0]    outstanding_q;
    logic [OW-1:0]    outstanding_d;

    logic [XW1-1:0]   size_ext;
    logic [XW1-1:0]   beats_calc;
    logic [XW1-1:0]   bursts_calc;
    logic [XW1-1:0]   rem_calc;
    logic [8:0]       last_len_calc;
    logic [7:0]       last_arlen_calc;
    logic [AW-1:0]    start_addr;

    logic             active;
    logic             ar_hs;
    logic             job_r_hs;
    logic             rlast_hs;
    logic             final_beat;

    // Job sizing, evaluated combinationally and captured on an accepted start
    assign size_ext        = {1'b0, ctrl_xfer_size_in_bytes};
    assign beats_calc      = (size_ext + XW1'(BPB - 1)) >> LOG_BPB;
    assign bursts_calc     = (beats_calc + XW1'(C_BURST_LEN - 1)) >> LOG_BURST;
    assign rem_calc        = beats_calc - ((beats_calc >> LOG_BURST) << LOG_BURST);
    assign last_len_calc   = (rem_calc == '0) ? 9'(C_BURST_LEN) : 9'(rem_calc);
    assign last_arlen_calc = 8'(last_len_calc - 9'd1);
    assign start_addr      = ctrl_addr_offset & ~AW'(BPB - 1);

    assign active     = (state_q == StIssue) || (state_q == StDrain);
    assign ar_hs      = arvalid_q & m_axi_arready;
    assign job_r_hs   = active & m_axi_rvalid & m_axis_tready;
    assign rlast_hs   = job_r_hs & m_axi_rlast;
    assign final_beat = (beats_rcvd_q + XW1'(1)) == total_beats_q;

    // Simultaneous AR issue and burst completion leaves the count unchanged
    always_comb begin
        outstanding_d = outstanding_q;
        if (ar_hs && !rlast_hs) begin
            if (outstanding_q != OW'(C_MAX_OUTSTANDING)) begin
                outstanding_d = outstanding_q + OW'(1);
            end
        end else if (!ar_hs && rlast_hs) begin
            if (outstanding_q != '0) begin
                outstanding_d = outstanding_q - OW'(1);
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q       <= StIdle;
            done_q        <= 1'b0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            last_arlen_q  <= '0;
            bursts_left_q <= '0;
            total_beats_q <= '0;
            beats_rcvd_q  <= '0;
            outstanding_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ctrl_start) begin
                        if (ctrl_xfer_size_in_bytes == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q       <= StIssue;
                            araddr_q      <= start_addr;
                            arlen_q       <= (bursts_calc == XW1'(1)) ? last_arlen_calc
                                                                      : 8'(C_BURST_LEN - 1);
                            last_arlen_q  <= last_arlen_calc;
                            bursts_left_q <= bursts_calc;
                            total_beats_q <= beats_calc;
                            beats_rcvd_q  <= '0;
                            outstanding_q <= '0;
                        end
                    end
                end
                StIssue: begin
                    outstanding_q <= outstanding_d;
                    if (job_r_hs) begin
                        beats_rcvd_q <= beats_rcvd_q + XW1'(1);
                    end
                    if (ar_hs) begin
                        bursts_left_q <= bursts_left_q - XW1'(1);
                        araddr_q      <= araddr_q + AW'(BURST_BYTES);
                        arlen_q       <= (bursts_left_q == XW1'(2)) ? last_arlen_q
                                                                    : 8'(C_BURST_LEN - 1);
                    end
                    // Raise or re-raise arvalid only while a slot is free after this cycle
                    if (ar_hs && (bursts_left_q == XW1'(1))) begin
                        state_q   <= StDrain;
                        arvalid_q <= 1'b0;
                    end else if (!arvalid_q || ar_hs) begin
                        arvalid_q <= (outstanding_d < OW'(C_MAX_OUTSTANDING));
                    end
                end
                StDrain: begin
                    outstanding_q <= outstanding_d;
                    if (job_r_hs) begin
                        beats_rcvd_q <= beats_rcvd_q + XW1'(1);
                        if (final_beat) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ctrl_done     = done_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;

    assign m_axi_rready  = m_axis_tready;
    assign m_axis_tvalid = m_axi_rvalid;
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tlast  = active & final_beat;

endmodule

// File: tb/tb_axonerve_kvs_rtl_example_axi_read_master.sv
// Directed bench for the KVS AXI read master: a small AXI slave model answers ARs with
// address-tagged beats; each scenario task checks its own results.
module tb_axonerve_kvs_rtl_example_axi_read_master;

    localparam int AW   = 64;
    localparam int DW   = 512;
    localparam int XSW  = 32;
    localparam int MAXO = 2;

    logic           ap_clk = 1'b0;
    logic           ap_rst_n = 1'b0;
    logic           ctrl_start = 1'b0;
    logic           ctrl_done;
    logic [AW-1:0]  ctrl_addr_offset = '0;
    logic [XSW-1:0] ctrl_xfer_size_in_bytes = '0;
    logic           m_axi_arvalid;
    logic           m_axi_arready = 1'b1;
    logic [AW-1:0]  m_axi_araddr;
    logic [7:0]     m_axi_arlen;
    logic           m_axi_rvalid = 1'b0;
    logic           m_axi_rready;
    logic [DW-1:0]  m_axi_rdata = '0;
    logic           m_axi_rlast = 1'b0;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b1;
    logic [DW-1:0]  m_axis_tdata;
    logic           m_axis_tlast;

    always #5 ap_clk = ~ap_clk;

    axonerve_kvs_rtl_example_axi_read_master #(
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (DW),
        .C_XFER_SIZE_WIDTH  (XSW),
        .C_BURST_LEN        (64),
        .C_MAX_OUTSTANDING  (MAXO)
    ) dut (
        .ap_clk                  (ap_clk),
        .ap_rst_n                (ap_rst_n),
        .ctrl_start              (ctrl_start),
        .ctrl_done               (ctrl_done),
        .ctrl_addr_offset        (ctrl_addr_offset),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .m_axi_arvalid           (m_axi_arvalid),
        .m_axi_arready           (m_axi_arready),
        .m_axi_araddr            (m_axi_araddr),
        .m_axi_arlen             (m_axi_arlen),
        .m_axi_rvalid            (m_axi_rvalid),
        .m_axi_rready            (m_axi_rready),
        .m_axi_rdata             (m_axi_rdata),
        .m_axi_rlast             (m_axi_rlast),
        .m_axis_tvalid           (m_axis_tvalid),
        .m_axis_tready           (m_axis_tready),
        .m_axis_tdata            (m_axis_tdata),
        .m_axis_tlast            (m_axis_tlast)
    );

    int chk = 0;
    int pass = 0;

    // Slave model: accepted ARs, current beat within the head burst
    logic [AW-1:0] q_addr[$];
    int            q_len[$];
    int            cur_beat;
    int            model_out;
    logic [AW-1:0] ar_addr_log[$];
    int            ar_len_log[$];

    int n_ar, n_beats, n_tlast, tlast_bad, data_err, done_cnt;
    int rready_bad, ar_unstable, at_max, arvalid_seen, rlast_cnt;
    logic [AW-1:0] exp_base;
    int            exp_beats;
    bit            r_hold = 1'b0;
    bit            tready_toggle = 1'b0;
    int            ar_stall_cfg = 0;
    int            ar_stall_left = 0;
    bit            prev_pending;
    logic [AW-1:0] prev_addr;
    logic [7:0]    prev_len;

    task automatic clear_stats();
        q_addr.delete();
        q_len.delete();
        ar_addr_log.delete();
        ar_len_log.delete();
        cur_beat = 0;     model_out = 0;    n_ar = 0;         n_beats = 0;
        n_tlast = 0;      tlast_bad = 0;    data_err = 0;     done_cnt = 0;
        rready_bad = 0;   ar_unstable = 0;  at_max = 0;       arvalid_seen = 0;
        rlast_cnt = 0;    prev_pending = 1'b0;
        ar_stall_left = ar_stall_cfg;
    endtask

    // One clock: drive at negedge, sample 1 ns later, update the slave model
    task automatic step();
        logic          ar_hs;
        logic          r_hs;
        logic [DW-1:0] exp_data;
        @(negedge ap_clk);
        m_axi_arready = (ar_stall_left == 0);
        m_axis_tready = tready_toggle ? ~m_axis_tready : 1'b1;
        m_axi_rvalid  = !r_hold && (q_addr.size() > 0);
        if (q_addr.size() > 0) begin
            m_axi_rdata = {448'd0, q_addr[0] + 64'(cur_beat) * 64'd64};
            m_axi_rlast = (cur_beat == q_len[0]);
        end else begin
            m_axi_rdata = '0;
            m_axi_rlast = 1'b0;
        end
        #1;
        ar_hs = m_axi_arvalid && m_axi_arready;
        r_hs  = m_axi_rvalid && m_axi_rready;
        if (m_axi_rready !== m_axis_tready) rready_bad++;
        if (m_axis_tvalid !== m_axi_rvalid || m_axis_tdata !== m_axi_rdata) data_err++;
        if (prev_pending && (m_axi_arvalid !== 1'b1 || m_axi_araddr !== prev_addr ||
                             m_axi_arlen !== prev_len)) ar_unstable++;
        prev_pending = m_axi_arvalid && !m_axi_arready;
        prev_addr    = m_axi_araddr;
        prev_len     = m_axi_arlen;
        if (m_axi_arvalid) arvalid_seen++;
        if (m_axi_arvalid && model_out >= MAXO) at_max++;
        if (m_axi_arvalid && !m_axi_arready && ar_stall_left > 0) ar_stall_left--;
        if (r_hs) begin
            exp_data = {448'd0, exp_base + 64'(n_beats) * 64'd64};
            n_beats++;
            if (m_axis_tdata !== exp_data) data_err++;
            if (m_axis_tlast !== 1'(n_beats == exp_beats)) tlast_bad++;
            if (m_axis_tlast) n_tlast++;
            if (m_axi_rlast) begin
                void'(q_addr.pop_front());
                void'(q_len.pop_front());
                cur_beat = 0;
                model_out--;
                rlast_cnt++;
            end else begin
                cur_beat++;
            end
        end
        if (ar_hs) begin
            ar_addr_log.push_back(m_axi_araddr);
            ar_len_log.push_back(int'(m_axi_arlen));
            q_addr.push_back(m_axi_araddr);
            q_len.push_back(int'(m_axi_arlen));
            n_ar++;
            model_out++;
            ar_stall_left = ar_stall_cfg;
        end
        if (ctrl_done) done_cnt++;
    endtask

    task automatic start_job(input logic [AW-1:0] base, input logic [XSW-1:0] size,
                             input logic [AW-1:0] aligned, input int beats);
        clear_stats();
        exp_base                = aligned;
        exp_beats               = beats;
        ctrl_addr_offset        = base;
        ctrl_xfer_size_in_bytes = size;
        ctrl_start              = 1'b1;
        step();
        ctrl_start              = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, input string name);
        int n = 0;
        while (done_cnt == 0 && n < max_cycles) begin
            step();
            n++;
        end
        chk++;
        if (done_cnt == 0) $display("FAIL %s_timeout: ctrl_done not seen in %0d cycles", name,
                                    max_cycles);
        else pass++;
        repeat (4) step();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge ap_clk);
        chk++; if (m_axi_arvalid !== 1'b0) $display("FAIL rst_arvalid got %b want 0", m_axi_arvalid); else pass++;
        chk++; if (ctrl_done !== 1'b0) $display("FAIL rst_done got %b want 0", ctrl_done); else pass++;
        chk++; if (m_axi_araddr !== 64'd0) $display("FAIL rst_araddr got %h want 0", m_axi_araddr); else pass++;
        chk++; if (m_axi_arlen !== 8'd0) $display("FAIL rst_arlen got %0d want 0", m_axi_arlen); else pass++;
        ap_rst_n = 1'b1;
        clear_stats();
        repeat (3) step();
        chk++; if (arvalid_seen !== 0) $display("FAIL idle_arvalid got %0d want 0", arvalid_seen); else pass++;
    endtask

    task automatic test_single_burst();
        start_job(64'h0000_0001_0000_0000, 32'd4096, 64'h0000_0001_0000_0000, 64);
        wait_done(400, "single");
        chk++; if (n_ar !== 1) $display("FAIL single_n_ar got %0d want 1", n_ar); else pass++;
        chk++; if (ar_addr_log.size() < 1 || ar_addr_log[0] !== 64'h0000_0001_0000_0000 || ar_len_log[0] != 63)
                   $display("FAIL single_ar got n=%0d want addr 100000000 len 63", ar_addr_log.size()); else pass++;
        chk++; if (n_beats !== 64) $display("FAIL single_beats got %0d want 64", n_beats); else pass++;
        chk++; if (n_tlast !== 1 || tlast_bad !== 0) $display("FAIL single_tlast got %0d/%0d want 1/0", n_tlast, tlast_bad); else pass++;
        chk++; if (data_err !== 0) $display("FAIL single_data got %0d errors want 0", data_err); else pass++;
        chk++; if (done_cnt !== 1) $display("FAIL single_done got %0d want 1", done_cnt); else pass++;
    endtask

    task automatic test_multi_burst();
        int exp_len[4] = '{63, 63, 63, 1};
        start_job(64'h0000_0002_0000_0025, 32'd12416, 64'h0000_0002_0000_0000, 194);
        wait_done(1000, "multi");
        chk++; if (n_ar !== 4) $display("FAIL multi_n_ar got %0d want 4", n_ar); else pass++;
        for (int i = 0; i < 4; i++) begin
            chk++;
            if (i >= ar_addr_log.size() || ar_addr_log[i] !== 64'h0000_0002_0000_0000 + 64'(i) * 64'h1000 ||
                ar_len_log[i] != exp_len[i])
                $display("FAIL multi_ar%0d got addr %h len %0d want len %0d", i,
                         (i < ar_addr_log.size()) ? ar_addr_log[i] : 64'd0,
                         (i < ar_len_log.size()) ? ar_len_log[i] : -1, exp_len[i]);
            else pass++;
        end
        chk++; if (n_beats !== 194) $display("FAIL multi_beats got %0d want 194", n_beats); else pass++;
        chk++; if (n_tlast !== 1 || tlast_bad !== 0) $display("FAIL multi_tlast got %0d/%0d want 1/0", n_tlast, tlast_bad); else pass++;
        chk++; if (data_err !== 0) $display("FAIL multi_data got %0d errors want 0", data_err); else pass++;
        chk++; if (done_cnt !== 1) $display("FAIL multi_done got %0d want 1", done_cnt); else pass++;
    endtask

    task automatic test_outstanding();
        int n;
        r_hold = 1'b1;
        start_job(64'h0000_0000_0000_8000, 32'd32768, 64'h0000_0000_0000_8000, 512);
        repeat (20) step();
        chk++; if (n_ar !== 2) $display("FAIL outst_hold_n_ar got %0d want 2", n_ar); else pass++;
        chk++; if (m_axi_arvalid !== 1'b0) $display("FAIL outst_hold_arvalid got %b want 0", m_axi_arvalid); else pass++;
        r_hold = 1'b0;
        n = 0;
        while (rlast_cnt == 0 && n < 200) begin
            step();
            n++;
        end
        chk++; if (rlast_cnt == 0 || n_ar !== 2) $display("FAIL outst_at_rlast got n_ar %0d rlasts %0d want 2/1", n_ar, rlast_cnt); else pass++;
        repeat (2) step();
        chk++; if (n_ar !== 3) $display("FAIL outst_after_rlast got %0d want 3", n_ar); else pass++;
        wait_done(2000, "outst");
        chk++; if (n_ar !== 8) $display("FAIL outst_n_ar got %0d want 8", n_ar); else pass++;
        chk++; if (n_beats !== 512) $display("FAIL outst_beats got %0d want 512", n_beats); else pass++;
        chk++; if (at_max !== 0) $display("FAIL outst_arvalid_at_max got %0d want 0", at_max); else pass++;
        chk++; if (n_tlast !== 1 || tlast_bad !== 0 || data_err !== 0)
                   $display("FAIL outst_stream got tlast %0d bad %0d data %0d want 1/0/0", n_tlast, tlast_bad, data_err); else pass++;
    endtask

    task automatic test_stall_toggle();
        ar_stall_cfg  = 5;
        tready_toggle = 1'b1;
        start_job(64'h0000_0000_0040_0000, 32'd8384, 64'h0000_0000_0040_0000, 131);
        wait_done(1500, "stall");
        chk++; if (n_ar !== 3) $display("FAIL stall_n_ar got %0d want 3", n_ar); else pass++;
        chk++; if (ar_len_log.size() < 3 || ar_len_log[2] != 2) $display("FAIL stall_last_len got n=%0d want len 2", ar_len_log.size()); else pass++;
        chk++; if (ar_unstable !== 0) $display("FAIL stall_ar_stable got %0d changes want 0", ar_unstable); else pass++;
        chk++; if (rready_bad !== 0) $display("FAIL stall_rready got %0d mismatches want 0", rready_bad); else pass++;
        chk++; if (n_beats !== 131) $display("FAIL stall_beats got %0d want 131", n_beats); else pass++;
        chk++; if (data_err !== 0 || tlast_bad !== 0 || n_tlast !== 1)
                   $display("FAIL stall_stream got data %0d tlastbad %0d tlast %0d want 0/0/1", data_err, tlast_bad, n_tlast); else pass++;
        ar_stall_cfg  = 0;
        tready_toggle = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic test_zero_size();
        clear_stats();
        ctrl_xfer_size_in_bytes = '0;
        ctrl_addr_offset        = 64'h1000;
        ctrl_start              = 1'b1;
        chk++; if (ctrl_done !== 1'b0) $display("FAIL zero_done_start_cycle got %b want 0", ctrl_done); else pass++;
        @(posedge ap_clk);
        #1;
        ctrl_start = 1'b0;
        chk++; if (ctrl_done !== 1'b1) $display("FAIL zero_done_pulse got %b want 1", ctrl_done); else pass++;
        @(posedge ap_clk);
        #1;
        chk++; if (ctrl_done !== 1'b0) $display("FAIL zero_done_end got %b want 0", ctrl_done); else pass++;
        repeat (4) step();
        chk++; if (arvalid_seen !== 0 || done_cnt !== 0)
                   $display("FAIL zero_quiet got arvalid %0d done %0d want 0/0", arvalid_seen, done_cnt); else pass++;
    endtask

    task automatic test_start_ignored();
        start_job(64'h0000_0000_0003_0000, 32'd4096, 64'h0000_0000_0003_0000, 64);
        repeat (5) step();
        ctrl_xfer_size_in_bytes = '0;
        ctrl_start              = 1'b1;
        step();
        ctrl_start              = 1'b0;
        wait_done(400, "ignore");
        chk++; if (done_cnt !== 1) $display("FAIL ignore_done got %0d want 1", done_cnt); else pass++;
        chk++; if (n_beats !== 64 || n_ar !== 1) $display("FAIL ignore_job got beats %0d ars %0d want 64/1", n_beats, n_ar); else pass++;
    endtask

    task automatic test_reset_mid_drain();
        r_hold = 1'b1;
        start_job(64'h0000_0000_0001_0000, 32'd8192, 64'h0000_0000_0001_0000, 128);
        repeat (10) step();
        chk++; if (n_ar !== 2) $display("FAIL mrst_pre_n_ar got %0d want 2", n_ar); else pass++;
        ap_rst_n = 1'b0;
        #1;
        chk++; if (m_axi_arvalid !== 1'b0 || ctrl_done !== 1'b0)
                   $display("FAIL mrst_async got arvalid %b done %b want 0/0", m_axi_arvalid, ctrl_done); else pass++;
        chk++; if (m_axi_araddr !== 64'd0 || m_axi_arlen !== 8'd0)
                   $display("FAIL mrst_ar_regs got %h/%0d want 0/0", m_axi_araddr, m_axi_arlen); else pass++;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        r_hold   = 1'b0;
        start_job(64'h0000_0000_0005_0000, 32'd4096, 64'h0000_0000_0005_0000, 64);
        wait_done(400, "mrst");
        chk++; if (n_ar !== 1 || ar_addr_log.size() < 1 || ar_addr_log[0] !== 64'h0000_0000_0005_0000)
                   $display("FAIL mrst_new_ar got n_ar %0d want 1 at 50000", n_ar); else pass++;
        chk++; if (n_beats !== 64 || n_tlast !== 1 || tlast_bad !== 0 || data_err !== 0)
                   $display("FAIL mrst_new_stream got beats %0d tlast %0d bad %0d data %0d want 64/1/0/0",
                            n_beats, n_tlast, tlast_bad, data_err); else pass++;
        chk++; if (done_cnt !== 1) $display("FAIL mrst_new_done got %0d want 1", done_cnt); else pass++;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_multi_burst();
        test_outstanding();
        test_stall_toggle();
        test_zero_size();
        test_start_ignored();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass, chk);
        $fatal(1, "watchdog");
    end

endmodule
